// File: rtl/freq_div_cfg_ctrl.sv
// Round-robin configuration sequencer driving the ratio update handshake of freq_div_by_n_10b.
// Optional divider bypass around ratio switches is enabled by defining FREQ_DIV_CFG_CTRL_BYPASS_EN.
module freq_div_cfg_ctrl #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned RATIO_W     = 10,
    parameter int unsigned MIN_RATIO   = 2,
    parameter int unsigned RESET_RATIO = 10,
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clkin,
    input  logic                    rstb,
    input  logic [NREQ-1:0]         cfg_req,
    input  logic [NREQ*RATIO_W-1:0] cfg_ratio,
    output logic [NREQ-1:0]         cfg_done,
    output logic [NREQ-1:0]         cfg_err,
    output logic [RATIO_W-1:0]      div_ratio,
    output logic                    div_upd_req,
    input  logic                    div_upd_ack,
    output logic                    div_bypass,
    output logic                    busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StReq, StRel} state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       gnt_q, gnt_d;
    logic [RATIO_W-1:0]     ratio_q, ratio_d;
    logic                   req_q, req_d;
    logic [NREQ-1:0]        done_q, done_d;
    logic [NREQ-1:0]        err_q, err_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic                   ack_s;
    logic                   timeout;
    logic [NREQ-1:0]        eligible;
    logic                   gnt_valid;
    logic [PTR_W-1:0]       gnt_idx;
    logic [NREQ-1:0]        gnt_new_oh;
    logic [RATIO_W-1:0]     gnt_ratio;
    logic                   gnt_reject;
    logic [NREQ-1:0]        gnt_oh;

    assign ack_s   = sync_q[SYNC_STAGES-1];
    assign timeout = (timer_q == TMR_W'(TIMEOUT));

    // Round-robin pick starting at ptr_q; a client whose done/err is pulsing this cycle is
    // masked so its still-high request is only seen as a new one on the following cycle.
    always_comb begin
        eligible   = cfg_req & ~(done_q | err_q);
        gnt_valid  = 1'b0;
        gnt_idx    = '0;
        gnt_new_oh = '0;
        gnt_ratio  = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!gnt_valid && eligible[j] && (PTR_W'(j) >= ptr_q)) begin
                gnt_valid     = 1'b1;
                gnt_idx       = PTR_W'(j);
                gnt_new_oh[j] = 1'b1;
                gnt_ratio     = cfg_ratio[j*RATIO_W +: RATIO_W];
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!gnt_valid && eligible[j] && (PTR_W'(j) < ptr_q)) begin
                gnt_valid     = 1'b1;
                gnt_idx       = PTR_W'(j);
                gnt_new_oh[j] = 1'b1;
                gnt_ratio     = cfg_ratio[j*RATIO_W +: RATIO_W];
            end
        end
        gnt_reject = (gnt_ratio < RATIO_W'(MIN_RATIO));
    end

    always_comb begin
        gnt_oh = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            gnt_oh[j] = (PTR_W'(j) == gnt_q);
        end
    end

    // State register
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ratio_q <= RATIO_W'(RESET_RATIO);
            req_q   <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            timer_q <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ratio_q <= ratio_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], div_upd_ack};
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    if (!gnt_reject) state_d = StLoad;
                end
            end
            StLoad: state_d = StReq;
            StReq: begin
                if (ack_s)        state_d = StRel;
                else if (timeout) state_d = StIdle;
            end
            StRel: begin
                if (!ack_s || timeout) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered-output and datapath next values
    always_comb begin
        gnt_d   = gnt_q;
        ratio_d = ratio_q;
        req_d   = req_q;
        done_d  = '0;
        err_d   = '0;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    if (gnt_reject) begin
                        err_d = gnt_new_oh;
                    end else begin
                        ratio_d = gnt_ratio;
                        gnt_d   = gnt_idx;
                    end
                end
            end
            StLoad: begin
                req_d   = 1'b1;
                timer_d = '0;
            end
            StReq: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    timer_d = '0;
                end else if (timeout) begin
                    req_d = 1'b0;
                    err_d = gnt_oh;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRel: begin
                if (!ack_s)       done_d  = gnt_oh;
                else if (timeout) err_d   = gnt_oh;
                else              timer_d = timer_q + 1'b1;
            end
            default: ;
        endcase
    end

`ifdef FREQ_DIV_CFG_CTRL_BYPASS_EN
    logic       byp_q, byp_d;
    logic [1:0] byp_cnt_q, byp_cnt_d;

    // Bypass rises with the new ratio and lingers two cycles after the handshake ends.
    always_comb begin
        byp_d     = byp_q;
        byp_cnt_d = byp_cnt_q;
        if (state_q == StIdle && state_d == StLoad) begin
            byp_d     = 1'b1;
            byp_cnt_d = 2'd0;
        end else if ((state_q == StReq || state_q == StRel) && state_d == StIdle) begin
            byp_cnt_d = 2'd2;
        end else if (byp_cnt_q != 2'd0) begin
            byp_cnt_d = byp_cnt_q - 2'd1;
            if (byp_cnt_q == 2'd1) byp_d = 1'b0;
        end
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            byp_q     <= 1'b0;
            byp_cnt_q <= 2'd0;
        end else begin
            byp_q     <= byp_d;
            byp_cnt_q <= byp_cnt_d;
        end
    end

    assign div_bypass = byp_q;
`else
    assign div_bypass = 1'b0;
`endif

    assign cfg_done    = done_q;
    assign cfg_err     = err_q;
    assign div_ratio   = ratio_q;
    assign div_upd_req = req_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_freq_div_cfg_ctrl.sv
// Directed bench for freq_div_cfg_ctrl with a simple four-phase divider ack model.
module tb_freq_div_cfg_ctrl;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned RATIO_W = 10;
    localparam int unsigned TIMEOUT = 1023;

    logic                    clkin = 1'b0;
    logic                    rstb  = 1'b1;
    logic [NREQ-1:0]         cfg_req = '0;
    logic [NREQ*RATIO_W-1:0] cfg_ratio = '0;
    logic [NREQ-1:0]         cfg_done;
    logic [NREQ-1:0]         cfg_err;
    logic [RATIO_W-1:0]      div_ratio;
    logic                    div_upd_req;
    logic                    div_upd_ack;
    logic                    div_bypass;
    logic                    busy;

    logic       ack_en  = 1'b1;
    logic [2:0] req_dly = 3'b000;

    int checks = 0;
    int errors = 0;

    always #5 clkin = ~clkin;

    // Divider model: ack follows req with a three-cycle delay in both directions.
    always @(posedge clkin) req_dly <= {req_dly[1:0], div_upd_req};
    assign div_upd_ack = ack_en & req_dly[2];

    freq_div_cfg_ctrl #(
        .NREQ        (NREQ),
        .RATIO_W     (RATIO_W),
        .MIN_RATIO   (2),
        .RESET_RATIO (10),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clkin       (clkin),
        .rstb        (rstb),
        .cfg_req     (cfg_req),
        .cfg_ratio   (cfg_ratio),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .div_ratio   (div_ratio),
        .div_upd_req (div_upd_req),
        .div_upd_ack (div_upd_ack),
        .div_bypass  (div_bypass),
        .busy        (busy)
    );

    task automatic test_reset();
        #2 rstb = 1'b0;
        repeat (3) @(negedge clkin);
        checks++;
        if ({cfg_done, cfg_err, div_upd_req, div_bypass, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got done=%b err=%b req=%b byp=%b busy=%b required all 0",
                     cfg_done, cfg_err, div_upd_req, div_bypass, busy);
        end
        checks++;
        if (div_ratio !== 10'd10) begin
            errors++;
            $display("FAIL reset_ratio: got %0d required 10", div_ratio);
        end
        rstb = 1'b1;
        repeat (2) @(negedge clkin);
        checks++;
        if ({cfg_done, cfg_err, div_upd_req, busy} !== 6'b0 || div_ratio !== 10'd10) begin
            errors++;
            $display("FAIL post_reset_idle: got req=%b busy=%b ratio=%0d required 0 0 10",
                     div_upd_req, busy, div_ratio);
        end
    endtask

    task automatic test_basic();
        logic             prev_req = 1'b0;
        logic [RATIO_W-1:0] prev_ratio;
        bit               rise_seen = 0;
        int               done_cnt = 0;
        int               err_cnt = 0;
        prev_ratio = div_ratio;
        cfg_ratio[9:0] = 10'd17;
        cfg_req = 2'b01;
        for (int c = 0; c < 60; c++) begin
            @(negedge clkin);
            if (div_upd_req && !prev_req && !rise_seen) begin
                rise_seen = 1;
                checks++;
                if (prev_ratio !== 10'd17) begin
                    errors++;
                    $display("FAIL basic_ratio_before_req: got %0d required 17", prev_ratio);
                end
            end
            if (cfg_done[0]) begin
                done_cnt++;
                checks++;
                if (div_upd_ack !== 1'b0 || div_upd_req !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_done_after_release: got ack=%b req=%b required 0 0",
                             div_upd_ack, div_upd_req);
                end
                cfg_req[0] = 1'b0;
            end
            if (cfg_err != 0 || cfg_done[1]) err_cnt++;
            prev_req   = div_upd_req;
            prev_ratio = div_ratio;
        end
        checks++;
        if (!rise_seen) begin
            errors++;
            $display("FAIL basic_req_rise: got no req rise required one");
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL basic_done_count: got done=%0d other=%0d required 1 0", done_cnt, err_cnt);
        end
        checks++;
        if (div_ratio !== 10'd17 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_final: got ratio=%0d busy=%b required 17 0", div_ratio, busy);
        end
    endtask

    task automatic test_reject();
        int bad = 0;
        cfg_ratio[19:10] = 10'd1;
        cfg_req = 2'b10;
        @(negedge clkin);
        checks++;
        if (cfg_err !== 2'b10 || cfg_done !== 2'b00) begin
            errors++;
            $display("FAIL reject_err_pulse: got err=%b done=%b required 10 00", cfg_err, cfg_done);
        end
        checks++;
        if (div_upd_req !== 1'b0 || div_ratio !== 10'd17 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_no_update: got req=%b ratio=%0d busy=%b required 0 17 0",
                     div_upd_req, div_ratio, busy);
        end
        cfg_req = 2'b00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clkin);
            if (div_upd_req !== 1'b0 || cfg_err !== 2'b00 || div_ratio !== 10'd17) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reject_quiet_after: got %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int errs_seen = 0;
        int who;
        cfg_ratio = {10'd25, 10'd12};
        cfg_req = 2'b11;
        for (int c = 0; c < 400 && n < 4; c++) begin
            @(negedge clkin);
            if (cfg_err != 0) errs_seen++;
            if (cfg_done != 0) begin
                who = cfg_done[1] ? 1 : 0;
                checks++;
                if (who != (n % 2) || cfg_done == 2'b11) begin
                    errors++;
                    $display("FAIL rr_order_%0d: got done=%b required client %0d", n, cfg_done, n % 2);
                end
                checks++;
                if (div_ratio !== ((n % 2 == 0) ? 10'd12 : 10'd25)) begin
                    errors++;
                    $display("FAIL rr_ratio_%0d: got %0d required %0d", n, div_ratio,
                             (n % 2 == 0) ? 12 : 25);
                end
                n++;
                if (n == 4) cfg_req = 2'b00;
            end
        end
        checks++;
        if (n != 4 || errs_seen != 0) begin
            errors++;
            $display("FAIL rr_count: got done=%0d err=%0d required 4 0", n, errs_seen);
        end
        repeat (3) @(negedge clkin);
    endtask

    task automatic test_timeout();
        int  req_cnt = 0;
        bit  got_err = 0;
        bit  got_done = 0;
        ack_en = 1'b0;
        cfg_ratio[9:0] = 10'd40;
        cfg_req = 2'b01;
        for (int c = 0; c < int'(TIMEOUT) + 100 && !got_err; c++) begin
            @(negedge clkin);
            if (div_upd_req) req_cnt++;
            if (cfg_done != 0) got_done = 1;
            if (cfg_err == 2'b01) begin
                got_err = 1;
                cfg_req = 2'b00;
            end
        end
        checks++;
        if (!got_err || got_done) begin
            errors++;
            $display("FAIL timeout_err: got err=%0d done=%0d required 1 0", got_err, got_done);
        end
        checks++;
        if (req_cnt < int'(TIMEOUT) || req_cnt > int'(TIMEOUT) + 1) begin
            errors++;
            $display("FAIL timeout_req_len: got %0d cycles required %0d..%0d", req_cnt, TIMEOUT,
                     TIMEOUT + 1);
        end
        checks++;
        if (div_upd_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got req=%b busy=%b required 0 0", div_upd_req, busy);
        end
        ack_en = 1'b1;
        @(negedge clkin);
        cfg_req = 2'b01;
        got_done = 0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            @(negedge clkin);
            if (cfg_done == 2'b01) begin
                got_done = 1;
                cfg_req = 2'b00;
            end
        end
        checks++;
        if (!got_done || div_ratio !== 10'd40) begin
            errors++;
            $display("FAIL timeout_recover: got done=%0d ratio=%0d required 1 40", got_done, div_ratio);
        end
        repeat (2) @(negedge clkin);
    endtask

    task automatic test_bypass();
        logic exp_on;
        bit   load_seen = 0;
        bit   done_seen = 0;
        int   k = 0;
        int   bad = 0;
`ifdef FREQ_DIV_CFG_CTRL_BYPASS_EN
        exp_on = 1'b1;
`else
        exp_on = 1'b0;
`endif
        cfg_ratio[19:10] = 10'd30;
        cfg_req = 2'b10;
        for (int c = 0; c < 80 && k < 2; c++) begin
            @(negedge clkin);
            if (done_seen) begin
                k++;
                checks++;
                if (div_bypass !== ((k == 1) ? exp_on : 1'b0)) begin
                    errors++;
                    $display("FAIL bypass_tail_%0d: got %b required %b", k, div_bypass,
                             (k == 1) ? exp_on : 1'b0);
                end
            end else if (cfg_done == 2'b10) begin
                done_seen = 1;
                cfg_req = 2'b00;
                checks++;
                if (div_bypass !== exp_on) begin
                    errors++;
                    $display("FAIL bypass_at_done: got %b required %b", div_bypass, exp_on);
                end
            end else if (load_seen) begin
                if (div_bypass !== exp_on) bad++;
            end else if (div_ratio === 10'd30) begin
                load_seen = 1;
                checks++;
                if (div_bypass !== exp_on || div_upd_req !== 1'b0) begin
                    errors++;
                    $display("FAIL bypass_at_load: got byp=%b req=%b required %b 0",
                             div_bypass, div_upd_req, exp_on);
                end
            end else if (div_bypass !== 1'b0) begin
                bad++;
            end
        end
        checks++;
        if (!load_seen || !done_seen || k != 2 || bad != 0) begin
            errors++;
            $display("FAIL bypass_window: got load=%0d done=%0d tail=%0d bad=%0d required 1 1 2 0",
                     load_seen, done_seen, k, bad);
        end
    endtask

    task automatic test_reset_mid();
        bit req_seen = 0;
        int pulses = 0;
        ack_en = 1'b0;
        cfg_ratio[9:0] = 10'd50;
        cfg_req = 2'b01;
        for (int c = 0; c < 20 && !req_seen; c++) begin
            @(negedge clkin);
            if (div_upd_req) req_seen = 1;
        end
        checks++;
        if (!req_seen) begin
            errors++;
            $display("FAIL midreset_req_rise: got none required req high");
        end
        repeat (3) @(negedge clkin);
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (div_upd_req !== 1'b0 || div_ratio !== 10'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got req=%b ratio=%0d busy=%b required 0 10 0",
                     div_upd_req, div_ratio, busy);
        end
        checks++;
        if (cfg_done !== 2'b00 || cfg_err !== 2'b00) begin
            errors++;
            $display("FAIL midreset_no_pulse: got done=%b err=%b required 00 00", cfg_done, cfg_err);
        end
        cfg_req = 2'b00;
        repeat (3) @(negedge clkin);
        rstb = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clkin);
            if (cfg_done != 0 || cfg_err != 0 || div_upd_req) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_after_release: got %0d active cycles required 0", pulses);
        end
        ack_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_round_robin();
        test_timeout();
        test_bypass();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
